// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
// Holds the transmitter state type, the line levels of the framing bits and
// the default bit period for a 50 MHz clock at 115200 baud.
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START_BIT,
        DATA,
        STOP,
        CHECK,
        DONE
    } UART_TX_STATE;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT = 1'b1;
    localparam int UART_CLKS_PER_BIT = 434;
endpackage

// File: rtl/baud_tick_counter.sv
// baud_tick_counter: bit-period timer shared by the UART transmitter and receiver.
// Ports: clk, reset (async active-low), clear (hold count at zero),
//        tick (high on the last cycle of each CLKS_PER_BIT-cycle bit period).
module baud_tick_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = cnt_q == CW'(CLKS_PER_BIT - 1);
    // Wrapping on tick restarts the next bit immediately, so bits never drift.
    assign cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/uart_fifo_tx.sv
// uart_fifo_tx: drains the result FIFO and sends each byte as a UART 8N1 frame.
// Ports: clk, reset (async active-low), start (drain request, IDLE only),
//        fifo_data_in/fifo_empty (FIFO read side), fifo_pop (1-cycle pop),
//        tx (serial line, idles high), busy, done (1-cycle pulse),
//        bytes_sent (frames sent in the current or last drain).
module uart_fifo_tx
    import uart_pkg::*;
#(
    parameter int WORD_LENGHT = 8,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int MAX_BYTES = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [WORD_LENGHT-1:0]         fifo_data_in,
    input  logic                           fifo_empty,
    output logic                           fifo_pop,
    output logic                           tx,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(MAX_BYTES+1)-1:0] bytes_sent
);
    localparam int BW = $clog2(MAX_BYTES + 1);
    localparam int IW = WORD_LENGHT > 1 ? $clog2(WORD_LENGHT) : 1;
    UART_TX_STATE state_q, state_d;
    logic [WORD_LENGHT-1:0] shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [BW-1:0] sent_q, sent_d;
    logic tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic tick, cnt_clear;

    // The bit timer only runs while a frame bit is on the line; holding it at
    // zero elsewhere makes every state entry start a fresh bit period.
    assign cnt_clear = !(state_q inside {START_BIT, DATA, STOP});

    baud_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk  (clk),
        .reset(reset),
        .clear(cnt_clear),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d = idx_q;
        sent_d = sent_q;
        busy_d = busy_q;
        done_d = state_q == DONE;
        case (state_q)
            IDLE: if (start) begin
                state_d = fifo_empty ? DONE : POP;
                busy_d = !fifo_empty;
                sent_d = '0;
            end
            POP: state_d = LOAD;
            LOAD: begin
                shift_d = fifo_data_in;
                idx_d = '0;
                state_d = START_BIT;
            end
            START_BIT: if (tick) state_d = DATA;
            DATA: if (tick) begin
                if (idx_q == IW'(WORD_LENGHT - 1)) state_d = STOP;
                else begin
                    idx_d = idx_q + 1'b1;
                    shift_d = shift_q >> 1;
                end
            end
            STOP: if (tick) begin
                state_d = CHECK;
                sent_d = sent_q + 1'b1;
            end
            CHECK: state_d = (!fifo_empty && sent_q < BW'(MAX_BYTES)) ? POP : DONE;
            DONE: begin
                state_d = IDLE;
                busy_d = 1'b0;
            end
        endcase
        // tx is registered from the next state so the line changes exactly
        // when the state does, with no input reaching the pin combinationally.
        tx_d = state_d == START_BIT ? UART_START_BIT : state_d == DATA ? shift_d[0] : UART_STOP_BIT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q <= '0;
            sent_q <= '0;
            tx_q <= UART_STOP_BIT;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q <= idx_d;
            sent_q <= sent_d;
            tx_q <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign fifo_pop = state_q == POP;
    assign tx = tx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign bytes_sent = sent_q;
endmodule

// File: tb/tb_uart_fifo_tx.sv
// tb_uart_fifo_tx: self-checking bench for uart_fifo_tx with a FIFO model and a line decoder.
module tb_uart_fifo_tx;
    localparam int C = 4;
    localparam int W = 8;
    localparam int M = 8;

    typedef struct {
        int n;
        bit incr;
        int exp_sent;
        bit exp_empty;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic fifo_empty = 1'b1;
    logic [7:0] fifo_dout = 8'h00;
    logic fifo_pop, tx, busy, done;
    logic [3:0] bytes_sent;
    logic push_req = 1'b0;
    logic flush_req = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int checks = 0, failures = 0, pops = 0, frames = 0, cyc = 0;
    bit infr = 0, fbad = 0;
    int fcyc = 0, last_end = -1;
    logic [7:0] fexp = 8'h00;
    logic eb;
    vec_t vecs[6];

    always #5 clk = ~clk;

    uart_fifo_tx #(.WORD_LENGHT(W), .CLKS_PER_BIT(C), .MAX_BYTES(M)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .start       (start),
        .fifo_data_in(fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_pop    (fifo_pop),
        .tx          (tx),
        .busy        (busy),
        .done        (done),
        .bytes_sent  (bytes_sent)
    );

    // Registered-output FIFO: data_out valid the cycle after a pop.
    always @(posedge clk) begin
        if (flush_req) fq.delete();
        if (fifo_pop && fq.size() > 0) begin
            fifo_dout <= fq[0];
            fq.pop_front();
        end
        if (push_req) fq.push_back(push_data);
        fifo_empty <= fq.size() == 0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line decoder: each frame must match the next expected byte cycle by cycle.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (fifo_pop) pops++;
        if (!rst_n || done) last_end = -1;
        if (!rst_n) infr = 0;
        else begin
            if (!infr && tx === 1'b0) begin
                infr = 1;
                fcyc = 0;
                fbad = 0;
                frames++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got frame expected none (cycle %0d)", cyc);
                    fexp = 8'h00;
                end else fexp = exp_q.pop_front();
                if (last_end >= 0) chk("frame_gap", cyc - last_end, 4);
            end
            if (infr) begin
                eb = fcyc < C ? 1'b0 : fcyc < (W + 1) * C ? fexp[(fcyc - C) / C] : 1'b1;
                if (tx !== eb) fbad = 1;
                fcyc++;
                if (fcyc == (W + 2) * C) begin
                    infr = 0;
                    last_end = cyc;
                    chk($sformatf("frame_bits_%02h", fexp), fbad, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] d);
        push_req = 1'b1;
        push_data = d;
        tick();
        push_req = 1'b0;
    endtask

    task automatic flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < (C * (W + 2) + 4) * M + 20) begin
            tick();
            lat++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done (cycle %0d)", cyc);
        end
    endtask

    task automatic drain(input int n, input bit incr, input int exp_sent, input bit exp_empty);
        int p0, f0, lat, k;
        logic [7:0] d;
        k = n < M ? n : M;
        for (int i = 0; i < n; i++) begin
            d = incr ? 8'(i + 1) : 8'($urandom);
            push(d);
            if (i < M) exp_q.push_back(d);
        end
        p0 = pops;
        f0 = frames;
        pulse_start();
        wait_done(lat);
        chk("busy_at_done", busy, 0);
        chk("bytes_sent", bytes_sent, exp_sent);
        chk("pop_count", pops - p0, k);
        chk("frame_count", frames - f0, k);
        chk("fifo_empty_after", fifo_empty, exp_empty);
        chk("frames_outstanding", exp_q.size(), 0);
        tick();
        chk("done_width", done, 0);
        flush();
        exp_q.delete();
    endtask

    initial begin
        int p0, f0, lat, txlow;
        vecs[0] = '{0, 1'b0, 0, 1'b1};
        vecs[1] = '{1, 1'b0, 1, 1'b1};
        vecs[2] = '{3, 1'b0, 3, 1'b1};
        vecs[3] = '{8, 1'b0, 8, 1'b1};
        vecs[4] = '{10, 1'b1, 8, 1'b0};
        vecs[5] = '{9, 1'b0, 8, 1'b0};

        repeat (3) tick();
        chk("rst_tx", tx, 1);
        chk("rst_pop", fifo_pop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bytes_sent", bytes_sent, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Empty FIFO: straight to done, no pop, line stays idle.
        p0 = pops;
        pulse_start();
        chk("empty_c1_pop", fifo_pop, 0);
        chk("empty_c1_busy", busy, 0);
        chk("empty_c1_done", done, 0);
        tick();
        chk("empty_c2_done", done, 1);
        chk("empty_c2_tx", tx, 1);
        chk("empty_bytes_sent", bytes_sent, 0);
        tick();
        chk("empty_done_width", done, 0);
        chk("empty_pops", pops - p0, 0);

        // Single 8'hA5 frame with exact start latency.
        push(8'hA5);
        exp_q.push_back(8'hA5);
        f0 = frames;
        pulse_start();
        chk("a5_c1_pop", fifo_pop, 1);
        chk("a5_c1_busy", busy, 1);
        chk("a5_c1_tx", tx, 1);
        tick();
        chk("a5_c2_pop", fifo_pop, 0);
        chk("a5_c2_tx", tx, 1);
        tick();
        chk("a5_c3_tx", tx, 0);
        wait_done(lat);
        chk("a5_bytes_sent", bytes_sent, 1);
        chk("a5_busy", busy, 0);
        chk("a5_frames", frames - f0, 1);
        tick();

        foreach (vecs[i]) drain(vecs[i].n, vecs[i].incr, vecs[i].exp_sent, vecs[i].exp_empty);
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(0, 10);
            drain(n, 1'b0, n < M ? n : M, n <= M);
        end

        // Start held high during active frames is ignored.
        for (int i = 0; i < 2; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            push(d);
            exp_q.push_back(d);
        end
        p0 = pops;
        f0 = frames;
        pulse_start();
        repeat (5) tick();
        start = 1'b1;
        repeat (60) tick();
        start = 1'b0;
        wait_done(lat);
        chk("hold_bytes_sent", bytes_sent, 2);
        chk("hold_pops", pops - p0, 2);
        chk("hold_frames", frames - f0, 2);
        repeat (3) tick();
        chk("hold_idle_busy", busy, 0);

        // Push during the stop bit is picked up at CHECK.
        push(8'h5A);
        exp_q.push_back(8'h5A);
        p0 = pops;
        pulse_start();
        repeat (39) tick();
        chk("late_push_stop_tx", tx, 1);
        push(8'h3C);
        exp_q.push_back(8'h3C);
        wait_done(lat);
        chk("late_push_bytes_sent", bytes_sent, 2);
        chk("late_push_pops", pops - p0, 2);
        chk("late_push_outstanding", exp_q.size(), 0);
        tick();

        // Reset in the middle of DATA of 8'hFF.
        push(8'hFF);
        exp_q.push_back(8'hFF);
        pulse_start();
        repeat (15) tick();
        chk("ff_mid_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_pop", fifo_pop, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        flush();
        exp_q.delete();
        p0 = pops;
        f0 = frames;
        txlow = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) txlow++;
        end
        chk("post_rst_idle_cycles", txlow, 0);
        chk("post_rst_pops", pops - p0, 0);
        chk("post_rst_frames", frames - f0, 0);
        chk("post_rst_bytes_sent", bytes_sent, 0);
        drain(2, 1'b0, 2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/uart_fifo_tx.md
Name: uart_fifo_tx

Overview:
- Draining end of the result FIFO: pops bytes from the FIFO on demand and serializes each one as a UART 8N1 frame on the tx line.
- Sits between FIFO_P3 outputs (data_out, empty_out) and the board TX pin.
- Provides the pop pulse that the top currently leaves unconnected.
- A single start pulse drains the FIFO until it is empty or MAX_BYTES frames have been sent; done then pulses.

Parameters:
WORD_LENGHT, 8, data bits per frame and width of fifo_data_in
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 2
MAX_BYTES, 8, upper bound on frames per start command (FIFO depth)

Ports:
clk  input  1  system clock (clk_high domain, same clock as the FIFO)
reset  input  1  asynchronous, active-low reset
start  input  1  synchronous pulse that requests a drain; sampled in IDLE only
fifo_data_in  input  WORD_LENGHT  FIFO data_out; registered, valid 1 cycle after pop
fifo_empty  input  1  FIFO empty_out
fifo_pop  output  1  one-cycle pop request to the FIFO
tx  output  1  serial line; idles high
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse when the drain completes
bytes_sent  output  $clog2(MAX_BYTES+1)  frames sent in the current or last drain

Behaviour:
- One clock. Reset is asynchronous and active-low. While reset=0: tx=1, fifo_pop=0, busy=0, done=0, bytes_sent=0, state=IDLE, counters cleared.
- FSM states: IDLE, POP, LOAD, START_BIT, DATA, STOP, CHECK, DONE.
- IDLE: tx=1. When start=1:
  - fifo_empty=1 -> go to DONE (no pop issued).
  - otherwise -> go to POP, set busy=1, clear bytes_sent.
  - start in any other state is ignored.
- POP: fifo_pop=1 for exactly 1 cycle -> LOAD.
- LOAD: capture fifo_data_in into the shift register -> START_BIT.
- START_BIT: tx=0 for CLKS_PER_BIT cycles -> DATA.
- DATA: send WORD_LENGHT bits, LSB first, each held CLKS_PER_BIT cycles. The bit index counter is 0..WORD_LENGHT-1 and does not wrap. -> STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On the last stop cycle, bytes_sent increments -> CHECK.
- CHECK (1 cycle, tx=1):
  - fifo_empty=0 and bytes_sent<MAX_BYTES -> POP.
  - otherwise -> DONE.
- DONE: done=1 for 1 cycle; busy drops to 0 in the same cycle -> IDLE. bytes_sent holds its value until the next accepted start.
- Baud counter runs 0..CLKS_PER_BIT-1. It reloads on every bit boundary and on every state entry, so each bit lasts exactly CLKS_PER_BIT cycles with no drift.
- Timing:
  - Frame length is (WORD_LENGHT+2)*CLKS_PER_BIT cycles.
  - Start to first tx falling edge is 3 cycles (IDLE sample, POP, LOAD).
  - The inter-frame gap beyond the stop bit is 3 cycles (CHECK, POP, LOAD), with tx held high.
- fifo_empty is sampled only in IDLE and CHECK. Pushes into the FIFO during a frame are picked up at CHECK.
- Asserting reset mid-frame returns tx to 1 immediately. No partial frame resumes after reset release.
- tx is driven from a flop; there is no combinational path from any input to tx.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum logic [2:0] UART_TX_STATE (the 8 states above);
  - constants UART_START_BIT=1'b0 and UART_STOP_BIT=1'b1;
  - default CLKS_PER_BIT.
- Sub-module baud_tick_counter (parameter CLKS_PER_BIT; ports clk, reset, clear, tick) generates the bit-boundary tick and is reused by the future UART receiver.

Test Plan:
1. CLKS_PER_BIT=4, FIFO holds 8'hA5; pulse start.
   - fifo_pop pulses at cycle 1.
   - tx falls at cycle 3; bit pattern 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
   - done pulses, bytes_sent=1, busy returns to 0.
2. fifo_empty=1; pulse start -> no fifo_pop, tx stays 1, done pulses 2 cycles after start, bytes_sent=0.
3. FIFO preloaded with 8'h01..8'h0A (10 entries, MAX_BYTES=8); pulse start.
   - Exactly 8 frames, 8'h01..8'h08 LSB-first.
   - Exactly 8 pops; bytes_sent=8; done pulses.
   - fifo_empty remains 0.
4. Start pulse held during an active frame -> ignored: the frame count and bit timing are unchanged, and no extra pop occurs.
5. Reset driven low in the middle of DATA of 8'hFF -> tx=1, busy=0 asynchronously. After release, the FSM is in IDLE and no bits are emitted until the next start.
6. FIFO holds 1 byte; push 8'h3C during that byte's stop bit -> CHECK sees fifo_empty=0, a second frame 8'h3C follows after the 3-cycle gap, bytes_sent=2.
